// File: rtl/overdrive_pkg.sv
// Shared widths, gain constants, scheduler state type and the gain slew helper
// used by the overdrive scheduler.
package overdrive_pkg;
  localparam int SAMPLE_W = 16;
  localparam int WIDE_W = 32;
  localparam int GAIN_FRAC_BITS = 4;
  localparam logic [15:0] GAIN_UNITY = 16'd16;

  typedef enum logic [0:0] {IDLE, RUN} sched_state_t;

  // Moves cur toward tgt by at most step. The 17-bit signed difference keeps
  // the comparison exact across the whole unsigned range, so the result never
  // overshoots and never wraps.
  function automatic logic [15:0] ramp_gain(input logic [15:0] cur,
                                            input logic [15:0] tgt,
                                            input logic [15:0] step);
    logic signed [16:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (d > $signed({1'b0, step}))
      ramp_gain = cur + step;
    else if (d < -$signed({1'b0, step}))
      ramp_gain = cur - step;
    else
      ramp_gain = tgt;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the channel after
// last, and the result is the first requester found, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         any
);
  logic [N-1:0] rot;
  int base;
  int k;

  // Rotate so the channel after last sits at bit 0, take the lowest set bit,
  // then rotate the index back.
  always_comb begin
    base = (int'(last) + 1) % N;
    rot = N'({req, req} >> base);
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) k = i;
    end
    grant = W'((base + k) % N);
    any = |req;
  end
endmodule

// File: rtl/overdrive_sched.sv
// Shares one overdrive datapath across N_CH channels round-robin, captures each
// result after DP_LATENCY cycles and slews the applied drive gain.
module overdrive_sched
  import overdrive_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int DP_LATENCY = 0,
  parameter int RAMP_STEP = 8,
  parameter logic [15:0] GAIN_RESET = GAIN_UNITY,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            in_valid,
  output logic [N_CH-1:0]            in_ready,
  input  logic [N_CH*SAMPLE_W-1:0]   in_sample,
  input  logic [15:0]                gain_target,
  output logic [15:0]                gain_current,
  output logic [SAMPLE_W-1:0]        dp_signal_in,
  output logic [15:0]                dp_gain,
  input  logic [WIDE_W-1:0]          dp_signal_out,
  output logic                       out_valid,
  output logic [CH_W-1:0]            out_ch,
  output logic [WIDE_W-1:0]          out_sample,
  output logic [N_CH-1:0]            ovr_flags
);
  localparam int CNT_W = (DP_LATENCY > 0) ? $clog2(DP_LATENCY + 1) : 1;

  sched_state_t          state;
  logic [N_CH-1:0]       pending;
  logic [SAMPLE_W-1:0]   hold [N_CH];
  logic [CH_W-1:0]       rr_last;
  logic [CH_W-1:0]       arb_grant;
  logic                  arb_any;
  logic [CNT_W-1:0]      cnt;

  // Handshake: a channel transfers on a cycle where in_valid[c] and in_ready[c]
  // are both high; in_valid[c] while in_ready[c] is low drops that sample and
  // latches the sticky overrun flag.
  assign in_ready = ~pending;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req   (pending),
    .last  (rr_last),
    .grant (arb_grant),
    .any   (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= '0;
      for (int c = 0; c < N_CH; c++) hold[c] <= '0;
      rr_last      <= CH_W'(N_CH - 1);
      cnt          <= '0;
      dp_signal_in <= '0;
      dp_gain      <= '0;
      out_valid    <= 1'b0;
      out_ch       <= '0;
      out_sample   <= '0;
      ovr_flags    <= '0;
      gain_current <= GAIN_RESET;
    end else begin
      out_valid <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        if (in_valid[c]) begin
          if (pending[c]) begin
            ovr_flags[c] <= 1'b1;
          end else begin
            hold[c]    <= in_sample[c*SAMPLE_W +: SAMPLE_W];
            pending[c] <= 1'b1;
          end
        end
      end
      case (state)
        IDLE: begin
          if (arb_any) begin
            dp_signal_in <= hold[arb_grant];
            dp_gain      <= gain_current;
            rr_last      <= arb_grant;
            cnt          <= CNT_W'(DP_LATENCY);
            state        <= RUN;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_sample       <= dp_signal_out;
            out_ch           <= rr_last;
            out_valid        <= 1'b1;
            pending[rr_last] <= 1'b0;
            // The ramp advances once per frame, paced by channel 0.
            if (rr_last == '0)
              gain_current <= ramp_gain(gain_current, gain_target, 16'(RAMP_STEP));
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
